iob_ram_sp_be_arb: RTL
======================

Name: iob_ram_sp_be_arb

Overview:
- Sequences and shares one single-port byte-enable RAM (1-cycle registered read, per-byte write enables) between two requesters, m0 and m1.
- After reset it zero-fills the whole RAM, then serves requests.
- Requests use a valid/ready handshake. Read data returns with rvalid exactly one cycle after acceptance.
- Sits between two bus masters (e.g. CPU data port and a DMA) and a single `iob_ram_sp_be` instance.

Parameters:
- DATA_W, 32, data width in bits; multiple of 8.
- ADDR_W, 4, word address width; RAM depth = 2**ADDR_W.
- INIT_EN, 1, 1 = zero-fill RAM after reset; 0 = go straight to SERVE.

Ports:
- clk_i  in  1  system clock
- arst_i  in  1  asynchronous reset, active-high
- init_done_o  out  1  high once zero-fill complete (or immediately when INIT_EN=0)
- m0_valid_i  in  1  m0 request valid
- m0_addr_i  in  ADDR_W  m0 word address
- m0_wdata_i  in  DATA_W  m0 write data
- m0_wstrb_i  in  DATA_W/8  m0 byte strobes; all-zero = read
- m0_ready_o  out  1  m0 request accepted this cycle
- m0_rvalid_o  out  1  m0 read data valid
- m0_rdata_o  out  DATA_W  m0 read data
- m1_valid_i, m1_addr_i, m1_wdata_i, m1_wstrb_i, m1_ready_o, m1_rvalid_o, m1_rdata_o: same as m0, for m1
- ram_en_o  out  1  RAM enable
- ram_we_o  out  DATA_W/8  RAM byte write enables
- ram_addr_o  out  ADDR_W  RAM address
- ram_d_o  out  DATA_W  RAM write data
- ram_d_i  in  DATA_W  RAM read data (valid the cycle after a read enable)

Behaviour:
- FSM states: INIT, SERVE. On arst_i, go to INIT if INIT_EN=1, else SERVE.
- Registered state:
  - init counter cnt, reset 0
  - round-robin pointer last, reset 1, so m0 wins the first tie
  - read-owner flags rd0_q and rd1_q, reset 0
- Reset values of outputs: init_done_o=0 (1 if INIT_EN=0); both ready_o=0; both rvalid_o=0; all ram_* outputs=0.
- INIT state:
  - Drive ram_en_o=1, ram_we_o=all ones, ram_addr_o=cnt, ram_d_o=0.
  - cnt increments each cycle.
  - When cnt = 2**ADDR_W-1, go to SERVE next cycle and set init_done_o=1.
  - Total INIT duration is 2**ADDR_W cycles.
  - Both ready_o stay 0; valid inputs are held off and are not lost.
- SERVE state, grant logic (combinational):
  - Only one valid: grant that requester.
  - Both valid: grant the requester not equal to last.
  - Neither valid: no grant, and ram_en_o=0.
- SERVE state, datapath:
  - mX_ready_o = grant to X, same cycle as valid.
  - ram_en_o=1.
  - ram_addr_o, ram_d_o and ram_we_o come from the granted requester's addr, wdata and wstrb.
- Handshake completes on valid & ready.
  - last updates to the granted index on every handshake.
  - A requester must hold valid and its payload stable until ready.
- Read response timing:
  - Handshake with wstrb=0 sets rdX_q=1 for one cycle.
  - In that cycle, mX_rvalid_o=1 and mX_rdata_o=ram_d_i.
  - Read latency is exactly 1 cycle. Back-to-back reads give one rvalid per cycle.
- Writes (wstrb≠0): no rvalid. Only the strobed bytes change.
- rdata_o of the non-owner is 0. rvalid_o is never asserted for both requesters in the same cycle.
- Throughput: one access per cycle. With both valid continuously, grants strictly alternate m0, m1, m0, …
- Reset mid-operation (arst_i asserted anywhere):
  - FSM returns to INIT and cnt restarts at 0.
  - Any pending rvalid is dropped.
  - The zero-fill re-runs in full.
- Address width: no wrap logic for requester addresses; cnt is ADDR_W+1 bits wide so the terminal count is unambiguous.

Decomposition:
- Shared package holds:
  - FSM state encoding: INIT=1'b0, SERVE=1'b1
  - localparam STRB_W = DATA_W/8
  - localparam DEPTH = 2**ADDR_W
- Natural sub-module: iob_rr_arb2, a 2-way round-robin grant with pointer register, reused elsewhere.
- The FSM, the init counter and the read-owner tracking stay in the top module.

Test Plan:
- Reset with INIT_EN=1, DEPTH=16 -> init_done_o rises after 16 cycles; ram_we_o=4'hF and ram_d_o=0 at addresses 0..15; then m0 reads addr 5 -> rdata 32'h0.
- m0 writes addr 3 with 32'h11223344, wstrb 4'b0101, then reads addr 3 -> m0_rvalid_o one cycle after ready, rdata 32'h00220044; m1_rvalid_o stays 0.
- m0 and m1 both valid continuously for 6 cycles, reading addrs 1 and 2 -> grants m0, m1, m0, m1, m0, m1; every rvalid goes to the matching owner, one cycle later.
- m1 alone issues 4 back-to-back reads of addrs 0..3, preloaded with 32+i -> m1_ready_o high every cycle; rdata 32, 33, 34, 35 on consecutive cycles.
- m0_valid_i high during INIT -> m0_ready_o=0 until the first SERVE cycle, then accepted that cycle.
- arst_i pulsed the cycle after an m0 read handshake -> no m0_rvalid_o; INIT restarts at cnt=0; init_done_o drops to 0.

Source files
------------

// File: rtl/iob_ram_sp_be_arb_pkg.sv
// iob_ram_sp_be_arb_pkg: shared FSM encoding and default geometry for the RAM arbiter.
package iob_ram_sp_be_arb_pkg;
  typedef enum logic {INIT = 1'b0, SERVE = 1'b1} state_t;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 4;
  localparam int STRB_W = DATA_W_DEF / 8;
  localparam int DEPTH = 2 ** ADDR_W_DEF;
endpackage

// File: rtl/iob_rr_arb2.sv
// iob_rr_arb2: 2-way round-robin grant; the pointer remembers the last winner so ties alternate.
module iob_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic last;
  assign gnt[0] = req[0] & (~req[1] | last);
  assign gnt[1] = req[1] & (~req[0] | ~last);
  always_ff @(posedge clk or posedge rst)
    if (rst) last <= 1'b1;
    else if (|gnt) last <= gnt[1];
endmodule

// File: rtl/iob_ram_sp_be_arb.sv
// iob_ram_sp_be_arb: zero-fills a single-port byte-enable RAM after reset, then shares it between two requesters.
module iob_ram_sp_be_arb
  import iob_ram_sp_be_arb_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 4,
  parameter bit INIT_EN = 1'b1
) (
  input  logic                clk_i,
  input  logic                arst_i,
  output logic                init_done_o,
  input  logic                m0_valid_i,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  input  logic [DATA_W/8-1:0] m0_wstrb_i,
  output logic                m0_ready_o,
  output logic                m0_rvalid_o,
  output logic [DATA_W-1:0]   m0_rdata_o,
  input  logic                m1_valid_i,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  input  logic [DATA_W/8-1:0] m1_wstrb_i,
  output logic                m1_ready_o,
  output logic                m1_rvalid_o,
  output logic [DATA_W-1:0]   m1_rdata_o,
  output logic                ram_en_o,
  output logic [DATA_W/8-1:0] ram_we_o,
  output logic [ADDR_W-1:0]   ram_addr_o,
  output logic [DATA_W-1:0]   ram_d_o,
  input  logic [DATA_W-1:0]   ram_d_i
);
  localparam int ND = 2 ** ADDR_W;
  state_t state, state_n;
  logic [ADDR_W:0] cnt;
  logic rd0_q, rd1_q, serve, live;
  logic [1:0] gnt;
  assign serve = state == SERVE;
  // reset also blanks the RAM port and grants, so nothing reaches the RAM while arst_i is high
  assign live = serve & ~arst_i;
  iob_rr_arb2 u_arb (
    .clk(clk_i),
    .rst(arst_i),
    .req({m1_valid_i, m0_valid_i} & {2{live}}),
    .gnt(gnt)
  );
  always_comb state_n = (state == INIT && cnt == (ADDR_W + 1)'(ND - 1)) ? SERVE : state;
  always_ff @(posedge clk_i or posedge arst_i)
    if (arst_i) begin
      state <= INIT_EN ? INIT : SERVE;
      cnt   <= '0;
      rd0_q <= 1'b0;
      rd1_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= serve ? cnt : cnt + 1'b1;
      rd0_q <= gnt[0] & ~|m0_wstrb_i;
      rd1_q <= gnt[1] & ~|m1_wstrb_i;
    end
  assign init_done_o = serve;
  assign m0_ready_o  = gnt[0];
  assign m1_ready_o  = gnt[1];
  assign m0_rvalid_o = rd0_q;
  assign m1_rvalid_o = rd1_q;
  assign m0_rdata_o  = rd0_q ? ram_d_i : '0;
  assign m1_rdata_o  = rd1_q ? ram_d_i : '0;
  assign ram_en_o    = ~arst_i & (~serve | |gnt);
  assign ram_we_o    = arst_i ? '0 : ~serve ? '1 : gnt[1] ? m1_wstrb_i : gnt[0] ? m0_wstrb_i : '0;
  assign ram_addr_o  = arst_i ? '0 : ~serve ? cnt[ADDR_W-1:0] : gnt[1] ? m1_addr_i : gnt[0] ? m0_addr_i : '0;
  assign ram_d_o     = (arst_i | ~serve) ? '0 : gnt[1] ? m1_wdata_i : gnt[0] ? m0_wdata_i : '0;
endmodule
